// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// No logic, no latency.
// No flow control; definitions only.
//
// Contents:
//   arb_state_t  - arbiter FSM state (ARB: re-arbitrate, HOLD: burst owner keeps port)
//   N_REQ_MAX    - largest supported requester count
//   credit_w()   - width of a counter that must hold 0..depth inclusive
package fifo_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int N_REQ_MAX = 8;

    // A credit counter must represent the full depth, not depth-1, hence +1.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Round-robin priority picker: first asserted request searching upward from last_i+1.
// Purely combinational, zero latency.
// No backpressure; win_o is all-zero when no request is present.
//
// Ports:
//   req_i  [N_REQ-1:0]  request vector
//   last_i [IW-1:0]     index of the previous winner (lowest priority this round)
//   win_o  [N_REQ-1:0]  one-hot winner (zero if req_i == 0)
//   idx_o  [IW-1:0]     binary index of the winner (0 if none)
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [N_REQ-1:0] win_o,
    output logic [IW-1:0]    idx_o
);

    logic found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        // Walk from the farthest candidate to the nearest; the last hit
        // written is the closest one after last_i, which has top priority.
        for (int k = N_REQ; k >= 1; k--) begin
            int j;
            j = int'(last_i) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req_i[j]) begin
                idx_o = IW'(j);
                found = 1'b1;
            end
        end
        win_o = found ? (N_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, credit flow control.
// Latency: req accepted at posedge -> fifo_wr_en_o/fifo_data_in_o one cycle later.
// Backpressure: gnt_o drops to zero when credits reach 0; no write is ever issued into a full FIFO.
//
// Optional feature macro: FIFO_ARB_BURST_EN (burst grants of up to MAX_BURST beats).
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req_i              per-requester valid
//   req_data_i         packed data, slice i belongs to requester i
//   gnt_o              one-hot combinational ready; beat accepted when req_i[i] & gnt_o[i] at posedge
//   fifo_wr_en_o       registered FIFO write enable
//   fifo_data_in_o     registered FIFO write data (holds last value when idle)
//   fifo_rd_done_i     consumer popped one entry this cycle
//   fifo_overflow_i    FIFO overflow flag
//   credits_o          free FIFO slots as tracked by the arbiter
//   err_overflow_o     sticky overflow indication, cleared only by reset
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REQ-1:0]                  req_i,
    input  logic [N_REQ*DATA_W-1:0]           req_data_i,
    output logic [N_REQ-1:0]                  gnt_o,
    output logic                              fifo_wr_en_o,
    output logic [DATA_W-1:0]                 fifo_data_in_o,
    input  logic                              fifo_rd_done_i,
    input  logic                              fifo_overflow_i,
    output logic [credit_w(FIFO_DEPTH)-1:0]   credits_o,
    output logic                              err_overflow_o
);

    localparam int              IW       = $clog2(N_REQ);
    localparam int              CW       = credit_w(FIFO_DEPTH);
    localparam logic [CW-1:0]   CRED_MAX = CW'(FIFO_DEPTH);

    generate
        if (N_REQ < 2 || N_REQ > N_REQ_MAX || MAX_BURST < 1 || FIFO_DEPTH < 1) begin : g_bad_cfg
            $error("fifo_wr_arbiter: unsupported parameter set");
        end
    endgenerate

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       last_gnt_q, last_gnt_d;
    logic [CW-1:0]       credits_q, credits_d;
    logic                wr_en_q;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;

    logic [N_REQ-1:0]    pick_win;
    logic [IW-1:0]       pick_idx;
    logic [N_REQ-1:0]    sel_oh;
    logic [IW-1:0]       sel_idx;
    logic                accept;
    logic [DATA_W-1:0]   sel_data;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req_i  (req_i),
        .last_i (last_gnt_q),
        .win_o  (pick_win),
        .idx_o  (pick_idx)
    );

    // Grant selection. In HOLD the burst owner is last_gnt_q: it was loaded
    // on the accept that opened the burst and only ever reloads with the
    // same index while holding, so the round-robin order effectively moves
    // on only once the burst ends.
    always_comb begin
        sel_oh  = pick_win;
        sel_idx = pick_idx;
        if (state_q == HOLD) begin
            sel_idx = last_gnt_q;
            sel_oh  = req_i[last_gnt_q] ? (N_REQ'(1) << last_gnt_q) : '0;
        end
        // Grant is gated by reset as well so the port is quiet while held in reset.
        gnt_o    = (rst_n && (credits_q != '0)) ? sel_oh : '0;
        accept   = |gnt_o;
        sel_data = req_data_i[sel_idx*DATA_W +: DATA_W];
    end

    // Credit bookkeeping. A simultaneous accept and pop cancel out; a pop
    // reported while already at full depth is spurious and ignored.
    always_comb begin
        credits_d = credits_q;
        if (accept && !fifo_rd_done_i) begin
            credits_d = credits_q - CW'(1);
        end else if (!accept && fifo_rd_done_i && (credits_q != CRED_MAX)) begin
            credits_d = credits_q + CW'(1);
        end
    end

    assign last_gnt_d = accept ? sel_idx : last_gnt_q;

`ifdef FIFO_ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB: begin
                if (accept && (MAX_BURST > 1)) begin
                    state_d    = HOLD;
                    beat_cnt_d = BW'(1);
                end
            end
            HOLD: begin
                // No accept means the owner dropped req or credits are gone.
                if (!accept || (int'(beat_cnt_q) + 1 >= MAX_BURST) || (credits_d == '0)) begin
                    state_d    = ARB;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d    = ARB;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    // Single-beat grants: every accepted beat goes back through arbitration.
    assign state_d = ARB;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            last_gnt_q <= IW'(N_REQ - 1);
            credits_q  <= CRED_MAX;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            credits_q  <= credits_d;
            wr_en_q    <= accept;
            if (accept) begin
                data_q <= sel_data;
            end
            err_q      <= err_q | fifo_overflow_i;
        end
    end

    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_data_in_o = data_q;
    assign credits_o      = credits_q;
    assign err_overflow_o = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus burst and reset sequences.
// Inputs change 1 time unit after posedge; outputs sampled at negedge.
// Expected values are hand-computed constants in the table.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      gnt;
    logic              wr_en;
    logic [DW-1:0]     wr_data;
    logic              rd_done;
    logic              ovf;
    logic [CW-1:0]     credits;
    logic              err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .MAX_BURST  (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_i           (req),
        .req_data_i      (req_data),
        .gnt_o           (gnt),
        .fifo_wr_en_o    (wr_en),
        .fifo_data_in_o  (wr_data),
        .fifo_rd_done_i  (rd_done),
        .fifo_overflow_i (ovf),
        .credits_o       (credits),
        .err_overflow_o  (err)
    );

    typedef struct {
        logic [3:0]  req;
        logic        rd;
        logic        ovf;
        logic [3:0]  gnt;
        logic        wr;
        logic [15:0] dat;
        logic [3:0]  cr;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] r, input logic rd_i, input logic ov,
                                input logic [3:0] g, input logic w, input logic [15:0] d,
                                input logic [3:0] c, input logic e);
        vec_t v;
        v.req = r; v.rd = rd_i; v.ovf = ov;
        v.gnt = g; v.wr = w; v.dat = d; v.cr = c; v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int n);
        req     = v.req;
        rd_done = v.rd;
        ovf     = v.ovf;
        @(negedge clk);
        chk($sformatf("v%0d gnt", n),     32'(gnt),     32'(v.gnt));
        chk($sformatf("v%0d wr_en", n),   32'(wr_en),   32'(v.wr));
        chk($sformatf("v%0d data", n),    32'(wr_data), 32'(v.dat));
        chk($sformatf("v%0d credits", n), 32'(credits), 32'(v.cr));
        chk($sformatf("v%0d err", n),     32'(err),     32'(v.err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;

        // Slice i carries 16'h1111*(i+1).
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        rst_n    = 1'b0;
        req      = 4'b1111;
        rd_done  = 1'b0;
        ovf      = 1'b0;

        //            req     rd    ovf   gnt     wr    data      cr     err
        // Saturate with all four requesting: 8 grants in order, then stall.
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 16'h0000, 4'd8, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 16'h1111, 4'd7, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 16'h2222, 4'd6, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 16'h3333, 4'd5, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 16'h4444, 4'd4, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 16'h1111, 4'd3, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 16'h2222, 4'd2, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 16'h3333, 4'd1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h4444, 4'd0, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h4444, 4'd0, 1'b0));
        // One pop at zero credits: no grant that cycle, exactly one grant next, to req0.
        vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h4444, 4'd0, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 16'h4444, 4'd1, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h1111, 4'd0, 1'b0));
        vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h1111, 4'd0, 1'b0));
        // Overflow pulse becomes sticky; pops refill credits and saturate at 8.
        vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h1111, 4'd0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h1111, 4'd0, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h1111, 4'd1, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h1111, 4'd2, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h1111, 4'd3, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h1111, 4'd4, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h1111, 4'd5, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h1111, 4'd6, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h1111, 4'd7, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h1111, 4'd8, 1'b1));
        // req=0101 with a pop every cycle: alternate 2,0 from pointer 0; credits stay 8.
        vecs.push_back(mk(4'b0101, 1'b1, 1'b0, 4'b0100, 1'b0, 16'h1111, 4'd8, 1'b1));
        vecs.push_back(mk(4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1, 16'h3333, 4'd8, 1'b1));
        vecs.push_back(mk(4'b0101, 1'b1, 1'b0, 4'b0100, 1'b1, 16'h1111, 4'd8, 1'b1));
        vecs.push_back(mk(4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1, 16'h3333, 4'd8, 1'b1));
        // Idle cycle leaves the pointer at 0, so req1 wins next.
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h1111, 4'd8, 1'b1));
        vecs.push_back(mk(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 16'h1111, 4'd8, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h2222, 4'd7, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h2222, 4'd7, 1'b1));

        // Reset state, with every requester asserting.
        repeat (2) @(posedge clk);
        #1;
        chk("reset gnt",     32'(gnt),     32'h0);
        chk("reset wr_en",   32'(wr_en),   32'h0);
        chk("reset data",    32'(wr_data), 32'h0);
        chk("reset credits", 32'(credits), 32'd8);
        chk("reset err",     32'(err),     32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Burst vs single-beat sequencing with req=0011 and a pop every cycle.
        rst_n = 1'b0;
        req   = 4'b0011;
        rd_done = 1'b1;
        ovf   = 1'b0;
        @(posedge clk);
        #1;
        chk("rst2 err", 32'(err), 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
`ifdef FIFO_ARB_BURST_EN
            exp_g = ((k / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
            exp_g = ((k % 2) == 0) ? 4'b0001 : 4'b0010;
`endif
            chk($sformatf("seq k%0d gnt", k), 32'(gnt), 32'(exp_g));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("seq credits", 32'(credits), 32'd8);
        @(posedge clk);
        #1;

        // Reset asserted while writes are streaming.
        req     = 4'b1111;
        rd_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
        end
        #1;
        chk("stream wr_en", 32'(wr_en), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst wr_en",   32'(wr_en),   32'h0);
        chk("midrst credits", 32'(credits), 32'd8);
        chk("midrst gnt",     32'(gnt),     32'h0);
        chk("midrst data",    32'(wr_data), 32'h0);
        @(posedge clk);
        #1;
        chk("inrst wr_en", 32'(wr_en), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst gnt",     32'(gnt),     32'b0001);
        chk("postrst credits", 32'(credits), 32'd8);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("postrst wr data", 32'(wr_data), 32'h1111);
        chk("postrst gnt2",    32'(gnt),     32'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
